// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle for the 4:1 round-robin mux arbiter.
// Requester side: req, a..d, out_ready. Arbiter side: out_valid, out_data, out_src, gnt, ack.
interface mux_rr_arbiter_if #(
    parameter int DW = 2
);
    logic [3:0]    req;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
    logic [3:0]    gnt;
    logic [3:0]    ack;

    // Requesters and downstream consumer.
    modport master (
        output req, a, b, c, d, out_ready,
        input  out_valid, out_data, out_src, gnt, ack
    );

    // The arbiter itself.
    modport slave (
        input  req, a, b, c, d, out_ready,
        output out_valid, out_data, out_src, gnt, ack
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer feeding one registered valid/ready channel.
// Ports: clk, rst (sync, active-high), bus (mux_rr_arbiter_if.slave).
module mux_rr_arbiter #(
    parameter int DW = 2
) (
    input logic                clk,
    input logic                rst,
    mux_rr_arbiter_if.slave    bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic [1:0]    out_src_q;
    logic [3:0]    gnt_q;

    logic          sel_found;
    logic [1:0]    sel_idx;
    logic [DW-1:0] sel_data;
    logic          hs;

    // First set request scanning upward from ptr, wrapping mod 4.
    always_comb begin
        logic [1:0] idx;
        sel_found = 1'b0;
        sel_idx   = ptr;
        idx       = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + k[1:0];
            if (!sel_found && bus.req[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    always_comb begin
        sel_data = bus.a;
        unique case (sel_idx)
            2'd0: sel_data = bus.a;
            2'd1: sel_data = bus.b;
            2'd2: sel_data = bus.c;
            2'd3: sel_data = bus.d;
        endcase
    end

    // Reset suppresses the ack so a discarded beat is never acknowledged.
    assign hs = out_valid_q & bus.out_ready & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            gnt_q       <= 4'b0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_found) begin
                        out_data_q  <= sel_data;
                        out_src_q   <= sel_idx;
                        gnt_q       <= 4'b0001 << sel_idx;
                        out_valid_q <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // out_data/out_src deliberately left as-is; qualified by out_valid.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        gnt_q       <= 4'b0000;
                        ptr         <= out_src_q + 2'd1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.gnt       = gnt_q;
    assign bus.ack       = hs ? gnt_q : 4'b0000;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter.
// Drives inputs 1ns after each rising edge and checks mid-cycle.
module tb_mux_rr_arbiter;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    mux_rr_arbiter_if #(.DW(2)) bus ();

    mux_rr_arbiter #(.DW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [1:0] src,
                            input logic [1:0] data, input logic [3:0] ack);
        #1;
        check({tag, ".valid"}, {7'd0, bus.out_valid}, 8'd1);
        check({tag, ".src"},   {6'd0, bus.out_src},   {6'd0, src});
        check({tag, ".data"},  {6'd0, bus.out_data},  {6'd0, data});
        check({tag, ".gnt"},   {4'd0, bus.gnt},       8'd1 << src);
        check({tag, ".ack"},   {4'd0, bus.ack},       {4'd0, ack});
    endtask

    task automatic chk_idle(input string tag);
        #1;
        check({tag, ".valid"}, {7'd0, bus.out_valid}, 8'd0);
        check({tag, ".gnt"},   {4'd0, bus.gnt},       8'd0);
        check({tag, ".ack"},   {4'd0, bus.ack},       8'd0);
    endtask

    logic [1:0] seq_src [5];
    logic [1:0] seq_dat [5];

    initial begin
        n_chk = 0;
        n_err = 0;
        seq_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        seq_dat = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};

        // Reset held with all requests and ready asserted.
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.a = 2'b00;
        bus.b = 2'b01;
        bus.c = 2'b10;
        bus.d = 2'b11;
        bus.out_ready = 1'b1;
        step();
        chk_idle("rst0");
        step();
        chk_idle("rst1");
        rst = 1'b0;

        // All four requesting: beats alternate with idle bubbles, 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            step();
            chk_beat($sformatf("rr%0d", i), seq_src[i], seq_dat[i],
                     4'b0001 << seq_src[i]);
            step();
            chk_idle($sformatf("rrb%0d", i));
        end
        // ptr is now 1.
        bus.req = 4'b0000;
        step();
        chk_idle("none");
        check("none.src_hold", {6'd0, bus.out_src}, 8'd0);

        // Single request on c.
        bus.req = 4'b0100;
        bus.c = 2'b10;
        step();
        chk_beat("c_only", 2'd2, 2'b10, 4'b0100);
        bus.req = 4'b0000;
        step();
        chk_idle("c_done");
        check("c_done.data_hold", {6'd0, bus.out_data}, 8'h2);

        // ptr=3: d wins first, then wraps to a.
        bus.req = 4'b1001;
        step();
        chk_beat("wrap_d", 2'd3, 2'b11, 4'b1000);
        step();
        chk_idle("wrap_b0");
        step();
        chk_beat("wrap_a", 2'd0, 2'b00, 4'b0001);
        bus.req = 4'b0000;
        step();
        chk_idle("wrap_b1");

        // Stall: b held for 5 cycles, inputs changed mid-beat are ignored.
        bus.req = 4'b0010;
        bus.b = 2'b01;
        bus.out_ready = 1'b0;
        step();
        chk_beat("stall0", 2'd1, 2'b01, 4'b0000);
        for (int i = 1; i < 5; i++) begin
            bus.req = 4'b1111;
            bus.a = 2'b11;
            step();
            chk_beat($sformatf("stall%0d", i), 2'd1, 2'b01, 4'b0000);
        end
        bus.req = 4'b0010;
        bus.a = 2'b00;
        bus.b = 2'b10;
        bus.out_ready = 1'b1;
        chk_beat("stall_rdy", 2'd1, 2'b01, 4'b0010);
        bus.req = 4'b0000;
        step();
        chk_idle("stall_done");
        check("stall_done.data_hold", {6'd0, bus.out_data}, 8'h1);

        // ptr=2: reset during a stalled beat discards it and clears ptr.
        bus.req = 4'b1111;
        bus.out_ready = 1'b0;
        step();
        chk_beat("pre_rst", 2'd2, 2'b10, 4'b0000);
        rst = 1'b1;
        #1;
        check("in_rst.ack", {4'd0, bus.ack}, 8'd0);
        step();
        chk_idle("post_rst");
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk_beat("after_rst", 2'd0, 2'b00, 4'b0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
